// File: rtl/sub_loader_pkg.sv
// Shared types and constants for the subtractor operand loader.
package sub_loader_pkg;

    // FSM encoding; it also drives the state LEDs, so the values are fixed.
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        VALID  = 2'd2
    } loader_state_t;

    // Flops in the metastability synchroniser on each raw button.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/button_debouncer.sv
// Button conditioning: synchroniser, stability counter, rising-edge pulse.
module button_debouncer
    import sub_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [CW-1:0]          cnt;
    logic                   deb;
    logic                   deb_q;

    assign synced = sync[SYNC_STAGES-1];

    // Synchronise, accept a level only after it has been stable long enough,
    // then emit one pulse per accepted press (releases are silent).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync        <= '0;
            cnt         <= '0;
            deb         <= 1'b0;
            deb_q       <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], btn_raw};
            deb_q       <= deb;
            press_pulse <= deb & ~deb_q;
            if (synced == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= synced;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_operand_loader.sv
// Operand capture stage: loads A then B from the switches on debounced
// presses and holds them valid until the subtractor stage accepts them.
module sub_operand_loader
    import sub_loader_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             btn_load,
    input  logic             btn_clear,
    input  logic             operands_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             operands_valid,
    output logic [1:0]       state_dbg
);

    loader_state_t state;
    logic          load_pulse;
    logic          clear_pulse;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_load),
        .press_pulse (load_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_clear),
        .press_pulse (clear_pulse)
    );

    assign state_dbg = state;

    // Load sequencing; clear wins over everything, accept wins over a load in VALID.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_pulse) begin
            state          <= LOAD_A;
            op_a           <= '0;
            op_b           <= '0;
            operands_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (load_pulse) begin
                        op_a  <= sw_data;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load_pulse) begin
                        op_b           <= sw_data;
                        state          <= VALID;
                        operands_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (operands_ready) begin
                        state          <= LOAD_A;
                        operands_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= LOAD_A;
                    operands_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_operand_loader.sv
// Directed bench for sub_operand_loader; operand pairs are checked by a
// scoreboard monitor on each rise of operands_valid.
module tb_sub_operand_loader;

    localparam int D = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_data = '0;
    logic         btn_load = 1'b0;
    logic         btn_clear = 1'b0;
    logic         operands_ready = 1'b0;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         operands_valid;
    logic [1:0]   state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    sub_operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw_data        (sw_data),
        .btn_load       (btn_load),
        .btn_clear      (btn_clear),
        .operands_ready (operands_ready),
        .op_a           (op_a),
        .op_b           (op_b),
        .operands_valid (operands_valid),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive buttons from a falling edge, hold, release and let it settle.
    task automatic press(input logic ld, input logic cl, input int hold);
        @(negedge clk);
        btn_load  = ld;
        btn_clear = cl;
        repeat (hold) @(negedge clk);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    // Scoreboard monitor: each new valid presentation pops one expected pair.
    initial begin
        logic       pv;
        logic [7:0] e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (operands_valid && !pv) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got %h expected none", {op_a, op_b});
                end else begin
                    e = exp_q.pop_front();
                    if ({op_a, op_b} !== e) begin
                        n_bad++;
                        $display("FAIL sb_pair: got %h expected %h", {op_a, op_b}, e);
                    end
                end
            end
            pv = operands_valid;
        end
    end

    initial begin
        // 1 reset with buttons held high
        btn_load  = 1'b1;
        btn_clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_a", 8'(op_a), 8'h0);
        check("rst_op_b", 8'(op_b), 8'h0);
        check("rst_valid", 8'(operands_valid), 8'h0);
        check("rst_state", 8'(state_dbg), 8'h0);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2 normal load with capture timing on the first press
        sw_data = 4'b1101;
        exp_q.push_back({4'b1101, 4'b0011});
        @(negedge clk);
        btn_load = 1'b1;
        repeat (D + 3) @(posedge clk);
        #1;
        check("timing_early_state", 8'(state_dbg), 8'h0);
        @(posedge clk);
        #1;
        check("timing_cap_state", 8'(state_dbg), 8'h1);
        check("timing_cap_op_a", 8'(op_a), 8'h0d);
        repeat (3) @(negedge clk);
        btn_load = 1'b0;
        repeat (D + 6) @(negedge clk);
        sw_data = 4'b0011;
        press(1'b1, 1'b0, 10);
        check("load_op_a", 8'(op_a), 8'h0d);
        check("load_op_b", 8'(op_b), 8'h03);
        check("load_valid", 8'(operands_valid), 8'h1);
        check("load_state", 8'(state_dbg), 8'h2);

        // 3 handshake: hold, ignored load, then accept
        operands_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_pair", {op_a, op_b}, 8'hd3);
        check("hold_valid", 8'(operands_valid), 8'h1);
        sw_data = 4'b0110;
        press(1'b1, 1'b0, 10);
        check("ign_load_pair", {op_a, op_b}, 8'hd3);
        check("ign_load_state", 8'(state_dbg), 8'h2);
        operands_ready = 1'b1;
        @(negedge clk);
        operands_ready = 1'b0;
        check("acc_valid", 8'(operands_valid), 8'h0);
        check("acc_state", 8'(state_dbg), 8'h0);
        check("acc_retain", {op_a, op_b}, 8'hd3);

        // 4 bounce: short glitches rejected, then one steady press
        sw_data = 4'b0011;
        repeat (2) begin
            btn_load = 1'b1;
            repeat (2) @(negedge clk);
            btn_load = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (D + 6) @(negedge clk);
        check("bounce_state", 8'(state_dbg), 8'h0);
        check("bounce_op_a", 8'(op_a), 8'h0d);
        press(1'b1, 1'b0, 8);
        check("steady_state", 8'(state_dbg), 8'h1);
        check("steady_op_a", 8'(op_a), 8'h03);

        // 5 clear beats a simultaneous load
        sw_data = 4'b1111;
        press(1'b1, 1'b1, 10);
        check("clr_pair", {op_a, op_b}, 8'h00);
        check("clr_state", 8'(state_dbg), 8'h0);
        check("clr_valid", 8'(operands_valid), 8'h0);

        // 6 reset mid-operation, then fresh load sequence
        sw_data = 4'b0010;
        press(1'b1, 1'b0, 10);
        check("pre_rst_state", 8'(state_dbg), 8'h1);
        check("pre_rst_op_a", 8'(op_a), 8'h02);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_pair", {op_a, op_b}, 8'h00);
        check("mid_rst_state", 8'(state_dbg), 8'h0);
        check("mid_rst_valid", 8'(operands_valid), 8'h0);
        sw_data = 4'b1001;
        exp_q.push_back({4'b1001, 4'b0110});
        press(1'b1, 1'b0, 10);
        check("post_rst_state", 8'(state_dbg), 8'h1);
        check("post_rst_op_a", 8'(op_a), 8'h09);
        sw_data = 4'b0110;
        press(1'b1, 1'b0, 10);
        check("post_rst_valid", 8'(operands_valid), 8'h1);
        operands_ready = 1'b1;
        @(negedge clk);
        operands_ready = 1'b0;
        check("final_state", 8'(state_dbg), 8'h0);

        repeat (2) @(negedge clk);
        check("sb_drained", 8'(exp_q.size()), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
